// File: rtl/prod_acc_pkg.sv
// Shared definitions for the product accumulator: FSM state encoding and default widths.
package prod_acc_pkg;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/product_accumulator.sv
// Sums a frame of unsigned multiplier products and presents the total over valid/ready.
// Optional macro ACC_SAT_EN: clamp the sum to all-ones on overflow instead of wrapping.
module product_accumulator
  import prod_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy
);

  state_t             state;
  state_t             state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   len_q;
  logic               ovf;
  logic [ACC_W:0]     sum;
  logic               beat;
  logic               last_beat;

  // Bit ACC_W of the widened sum is the carry out of the accumulator.
  function automatic logic [ACC_W-1:0] acc_update(input logic [ACC_W:0] s);
`ifdef ACC_SAT_EN
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    return s[ACC_W-1:0];
`endif
  endfunction

  assign sum       = {1'b0, acc} + {{(ACC_W - PROD_W + 1){1'b0}}, in_prod};
  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (cnt == len_q - CNT_W'(1));

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_acc   = acc;
  assign out_ovf   = ovf;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : ACCUM;
      ACCUM:   if (last_beat) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Frame datapath: start clears the running sum, each accepted beat folds in one product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      ovf   <= 1'b0;
    end else if (state == IDLE && start) begin
      acc   <= '0;
      cnt   <= '0;
      len_q <= len;
      ovf   <= 1'b0;
    end else if (beat) begin
      acc <= acc_update(sum);
      cnt <= cnt + CNT_W'(1);
      if (sum[ACC_W]) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator with a narrow accumulator so overflow is reachable.
module tb_product_accumulator;

  localparam int PROD_W  = 8;
  localparam int ACC_W   = 10;
  localparam int CNT_W   = 4;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic              out_ovf;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned prods[$];

  product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one frame over the products in prods[0..n-1]; expected result is the plain
  // arithmetic sum, reduced by the overflow rule of the build.
  task automatic do_frame(input int n, input int gap_min, input int gap_max,
                          input int rdy_wait, input bit hold_start);
    int unsigned      total;
    bit               exp_ovf;
    logic [ACC_W-1:0] exp_acc;
    total = 0;
    for (int i = 0; i < n; i++) total += prods[i];
    exp_ovf = (total > ACC_MAX);
`ifdef ACC_SAT_EN
    exp_acc = exp_ovf ? ACC_W'(ACC_MAX) : ACC_W'(total);
`else
    exp_acc = ACC_W'(total);
`endif
    check("idle_before_start", busy, 0);
    start = 1'b1;
    len   = CNT_W'(n);
    tick();
    start = hold_start;
    len   = CNT_W'($urandom_range(0, 15));
    check("busy_after_start", busy, 1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        repeat ($urandom_range(gap_max, gap_min)) begin
          in_valid = 1'b0;
          in_prod  = PROD_W'($urandom_range(0, 255));
          tick();
        end
      end
      check("in_ready_accum", in_ready, 1);
      check("early_valid", out_valid, 0);
      in_valid = 1'b1;
      in_prod  = PROD_W'(prods[i]);
      tick();
      in_valid = 1'b0;
    end
    check("out_valid", out_valid, 1);
    check("in_ready_done", in_ready, 0);
    check("out_acc", out_acc, exp_acc);
    check("out_ovf", out_ovf, exp_ovf);
    out_ready = 1'b0;
    repeat (rdy_wait) begin
      tick();
      check("valid_hold", out_valid, 1);
      check("acc_hold", out_acc, exp_acc);
    end
    out_ready = 1'b1;
    start     = hold_start;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check("idle_after_hs", busy, 0);
    check("valid_after_hs", out_valid, 0);
  endtask

  task automatic fill(input int n, input int unsigned val, input bit rnd);
    prods.delete();
    for (int i = 0; i < n; i++) prods.push_back(rnd ? $urandom_range(0, 255) : val);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_prod   = '0;
    out_ready = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 0);
    check("rst_acc", out_acc, 0);
    check("rst_ovf", out_ovf, 0);
    tick();
    rst = 1'b0;
    tick();

    // Reset after two beats of a five-beat frame
    start = 1'b1;
    len   = CNT_W'(5);
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_prod  = 8'h40;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_acc", out_acc, 0);
    tick();
    rst = 1'b0;
    tick();
    check("abort_still_idle", out_valid, 0);
    fill(3, 9, 1'b0);
    do_frame(3, 0, 0, 0, 1'b0);

    // len=4 of 0xE1, immediate ready
    fill(4, 'hE1, 1'b0);
    do_frame(4, 0, 0, 0, 1'b0);

    // Gapped beats 2,5,7
    prods.delete();
    prods.push_back(2);
    prods.push_back(5);
    prods.push_back(7);
    do_frame(3, 1, 1, 0, 1'b0);

    // Zero-length frame with start held afterwards
    do_frame(0, 0, 0, 2, 1'b1);

    // Overflow frame: 5 x 0xE1
    fill(5, 'hE1, 1'b0);
    do_frame(5, 0, 0, 0, 1'b0);

    // Consumer stalls for 5 cycles
    fill(2, 'h33, 1'b0);
    do_frame(2, 0, 0, 5, 1'b1);

    // Random frames
    for (int f = 0; f < 20; f++) begin
      int n;
      n = $urandom_range(0, 15);
      fill(n, 0, 1'b1);
      do_frame(n, 0, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
